// File: rtl/carry_look_ahead_adder_4bit_if.sv
// rtl/carry_look_ahead_adder_4bit_if.sv - operand/result bundle for the 4-bit look-ahead adder
interface carry_look_ahead_adder_4bit_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic       PG;
    logic       GG;

    // master supplies operands and observes the registered result
    modport master (
        output A, B, Cin,
        input  Sum, Cout, PG, GG
    );

    modport slave (
        input  A, B, Cin,
        output Sum, Cout, PG, GG
    );
endinterface

// File: rtl/carry_look_ahead_adder_4bit.sv
// rtl/carry_look_ahead_adder_4bit.sv - 4-bit carry look-ahead adder with one registered output stage
module carry_look_ahead_adder_4bit (
    input  logic                              clk,
    input  logic                              rst,
    carry_look_ahead_adder_4bit_if.slave      bus
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] sum_d;
    logic       cout_d;
    logic       pg_d;
    logic       gg_d;

    logic [3:0] sum_q;
    logic       cout_q;
    logic       pg_q;
    logic       gg_q;

    assign p = bus.A ^ bus.B;
    assign g = bus.A & bus.B;

    // every carry is a flat sum-of-products of g, p and Cin; none feeds another
    assign c[0] = bus.Cin;
    assign c[1] = g[0] | (p[0] & bus.Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bus.Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bus.Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bus.Cin);

    assign sum_d  = p ^ c[3:0];
    assign cout_d = c[4];
    assign pg_d   = &p;
    assign gg_d   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
            pg_q   <= 1'b0;
            gg_q   <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            pg_q   <= pg_d;
            gg_q   <= gg_d;
        end
    end

    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.PG   = pg_q;
    assign bus.GG   = gg_q;
endmodule

// File: tb/tb_carry_look_ahead_adder_4bit.sv
// tb/tb_carry_look_ahead_adder_4bit.sv - scoreboard bench for carry_look_ahead_adder_4bit
module tb_carry_look_ahead_adder_4bit;
    logic clk;
    logic rst;

    carry_look_ahead_adder_4bit_if bus ();

    carry_look_ahead_adder_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       pg;
        logic       gg;
        logic       cin;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    // reference: plain integer arithmetic on the operand values
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic r, input string tag);
        exp_t e;
        int   total;
        @(posedge clk);
        #1;
        rst     = r;
        bus.A   = a;
        bus.B   = b;
        bus.Cin = cin;
        total   = int'(a) + int'(b) + int'(cin);
        e.tag   = tag;
        e.cin   = cin;
        if (r) begin
            e.sum = 4'd0; e.cout = 1'b0; e.pg = 1'b0; e.gg = 1'b0;
        end else begin
            e.sum  = 4'(total % 16);
            e.cout = (total >= 16);
            e.pg   = ((a ^ b) == 4'hF);
            e.gg   = ((int'(a) + int'(b)) >= 16);
        end
        exp_q.push_back(e);
    endtask

    // monitor: an entry queued before an edge is the result visible after it
    initial begin
        int   pending;
        exp_t e;
        forever begin
            @(posedge clk);
            pending = exp_q.size();
            @(negedge clk);
            if (pending > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({bus.Cout, bus.Sum, bus.PG, bus.GG} !== {e.cout, e.sum, e.pg, e.gg}) begin
                    n_fail++;
                    $display("FAIL %s: got Cout=%b Sum=%b PG=%b GG=%b, expected Cout=%b Sum=%b PG=%b GG=%b",
                             e.tag, bus.Cout, bus.Sum, bus.PG, bus.GG, e.cout, e.sum, e.pg, e.gg);
                end
                n_vec++;
                if (bus.Cout !== (bus.GG | (bus.PG & e.cin))) begin
                    n_fail++;
                    $display("FAIL %s_invariant: Cout=%b but GG|(PG&Cin)=%b",
                             e.tag, bus.Cout, bus.GG | (bus.PG & e.cin));
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        bus.A   = 4'hF;
        bus.B   = 4'hF;
        bus.Cin = 1'b1;

        apply(4'hF, 4'hF, 1'b1, 1'b1, "reset0");
        apply(4'hF, 4'hF, 1'b1, 1'b1, "reset1");

        apply(4'b1011, 4'b1101, 1'b0, 1'b0, "dir_1011_1101");
        apply(4'b0101, 4'b0011, 1'b0, 1'b0, "dir_0101_0011");
        apply(4'b1110, 4'b0001, 1'b0, 1'b0, "dir_1110_0001");
        apply(4'b1001, 4'b0110, 1'b1, 1'b0, "full_propagate");
        apply(4'b1111, 4'b1111, 1'b0, 1'b0, "b2b_ones");
        apply(4'b0000, 4'b0000, 1'b0, 1'b0, "b2b_zeros");

        // reset in the middle of a stream drops the in-flight operands
        apply(4'b1111, 4'b0001, 1'b1, 1'b1, "midreset");
        apply(4'b0111, 4'b0111, 1'b1, 1'b0, "after_reset");

        for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = 9'(v);
            apply(vv[8:5], vv[4:1], vv[0], 1'b0, "exhaustive");
        end

        for (int k = 0; k < 200; k++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rc;
            logic       rr;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 19) == 0);
            apply(ra, rb, rc, rr, "random");
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        stim_done = 1'b1;
    end

    initial begin
        fork
            wait (stim_done);
            begin
                repeat (5000) @(posedge clk);
                $display("FAIL timeout: stimulus did not finish within 5000 cycles");
                n_fail++;
            end
        join_any
        disable fork;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/carry_look_ahead_adder_4bit.md
Name:
carry_look_ahead_adder_4bit

Overview:
- 4-bit carry look-ahead adder: Sum = A + B + Cin, with carry-out.
- Built structurally from per-bit generate/propagate cells and a look-ahead carry unit; no ripple chain.
- Results are registered in a single pipeline stage.
- Also exports group propagate/generate so instances can be cascaded under a second-level look-ahead unit.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk    input   1  single clock; all state updates on rising edge.
- rst    input   1  reset, synchronous, active-high.
- A      input   4  addend A, unsigned.
- B      input   4  addend B, unsigned.
- Cin    input   1  carry-in.
- Sum    output  4  registered sum bits [3:0].
- Cout   output  1  registered carry-out (bit 4 of A+B+Cin).
- PG     output  1  registered group propagate.
- GG     output  1  registered group generate.

Behaviour:
- Per bit i (0..3): p[i] = A[i] xor B[i]; g[i] = A[i] and B[i].
- Carries are computed in flattened two-level look-ahead form from g, p and Cin; no carry depends on another computed carry:
  - c1 = g0 | p0·Cin
  - c2 = g1 | p1·g0 | p1·p0·Cin
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·Cin
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·Cin
- Sum bits: s[i] = p[i] xor c[i], with c0 = Cin.
- Group terms:
  - PG = p3·p2·p1·p0
  - GG = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - Invariant: Cout = GG | PG·Cin.
- Timing:
  - Combinational result is captured into output registers on every rising clk edge.
  - Latency is exactly 1 cycle: inputs present before edge N appear on the outputs after edge N.
  - No handshake; a new operand set is accepted every cycle (throughput 1/cycle).
- Reset:
  - When rst=1 at a rising edge: Sum=4'b0000, Cout=0, PG=0, GG=0, regardless of inputs.
  - Reset takes priority over capture.
  - When rst deasserts, the first capture occurs at the next edge with rst=0.
  - Reset mid-stream discards the in-flight result; no partial state remains.
- Arithmetic:
  - Unsigned modulo-16 sum; Cout carries the 16's weight, so {Cout,Sum} = A+B+Cin exactly (range 0..31).
  - No overflow flag; signed interpretation is left to the user.
- Boundary conditions:
  - All-ones propagate chain (A xor B = 1111) with Cin=1 must yield Sum=0000, Cout=1, PG=1, GG=0.
  - X/Z on inputs is not handled specially.

Test Plan:
- Reset: hold rst=1 for 2 cycles with A=1111, B=1111, Cin=1 -> Sum=0000, Cout=0, PG=0, GG=0; first valid result appears one edge after rst drops.
- A=1011, B=1101, Cin=0 -> next cycle Sum=1000, Cout=1, PG=0, GG=1.
- A=0101, B=0011, Cin=0 -> Sum=1000, Cout=0.
- Then A=1110, B=0001, Cin=0 -> Sum=1111, Cout=0, PG=1, GG=0.
- A=1001, B=0110, Cin=1 (full propagate) -> Sum=0000, Cout=1, PG=1, GG=0.
- Back-to-back: A=1111, B=1111, Cin=0 followed by A=0000, B=0000, Cin=0 on consecutive cycles -> outputs Sum=1110/Cout=1/GG=1 then Sum=0000/Cout=0, one cycle apart.
- Exhaustive: all 512 (A,B,Cin) combinations streamed one per cycle -> {Cout,Sum} equals A+B+Cin one cycle later, and Cout equals GG|(PG&Cin) every cycle.
